// File: rtl/wash_pkg.sv
// Shared types and defaults for the wash cycle sequencer: state codes,
// phase duration defaults and the terminal-count helper.
package wash_pkg;

  localparam int unsigned TIMER_W         = 32;
  localparam int unsigned FILL_SEC_DEF    = 120;
  localparam int unsigned WASH_SEC_DEF    = 300;
  localparam int unsigned RINSE_SEC_DEF   = 120;
  localparam int unsigned SPIN_SEC_DEF    = 60;
  localparam int unsigned CYC_PER_SEC_DEF = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Last timer value of a phase; a zero-length phase still lasts one cycle.
  function automatic logic [TIMER_W-1:0] phase_tc(input int unsigned sec,
                                                  input int unsigned cps);
    logic [TIMER_W-1:0] n;
    n = TIMER_W'(sec * cps);
    if (n == TIMER_W'(0)) n = TIMER_W'(1);
    return n - TIMER_W'(1);
  endfunction

endpackage

// File: rtl/wash_cycle_sequencer_if.sv
// Control and status bundle between the machine front panel and the sequencer.
interface wash_cycle_sequencer_if;

  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic [2:0] state_o;
  logic       fill_valve;
  logic       wash_motor;
  logic       spin_motor;
  logic       wash_done;

  modport master (
    output coin_in, double_wash, timer_pause,
    input  state_o, fill_valve, wash_motor, spin_motor, wash_done
  );

  modport slave (
    input  coin_in, double_wash, timer_pause,
    output state_o, fill_valve, wash_motor, spin_motor, wash_done
  );

endinterface

// File: rtl/phase_timer.sv
// Phase duration counter: counts unfrozen cycles and flags the terminal one.
module phase_timer
  import wash_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               freeze,
  input  logic [TIMER_W-1:0] tc,
  output logic               phase_end
);

  logic [TIMER_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)        cnt_d = '0;
    else if (!freeze) cnt_d = cnt_q + TIMER_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // A frozen terminal count must not advance the phase.
  assign phase_end = (cnt_q == tc) && !freeze;

endmodule

// File: rtl/wash_cycle_sequencer.sv
// Coin-operated wash cycle controller: FILL, WASH, RINSE (optionally twice),
// SPIN with pause, then a one-cycle DONE.
module wash_cycle_sequencer
  import wash_pkg::*;
#(
  parameter int unsigned FILL_SEC    = FILL_SEC_DEF,
  parameter int unsigned WASH_SEC    = WASH_SEC_DEF,
  parameter int unsigned RINSE_SEC   = RINSE_SEC_DEF,
  parameter int unsigned SPIN_SEC    = SPIN_SEC_DEF,
  parameter int unsigned CYC_PER_SEC = CYC_PER_SEC_DEF
) (
  input  logic                  clk,
  input  logic                  Counter_RST,
  wash_cycle_sequencer_if.slave bus
);

  localparam logic [TIMER_W-1:0] TC_FILL  = phase_tc(FILL_SEC,  CYC_PER_SEC);
  localparam logic [TIMER_W-1:0] TC_WASH  = phase_tc(WASH_SEC,  CYC_PER_SEC);
  localparam logic [TIMER_W-1:0] TC_RINSE = phase_tc(RINSE_SEC, CYC_PER_SEC);
  localparam logic [TIMER_W-1:0] TC_SPIN  = phase_tc(SPIN_SEC,  CYC_PER_SEC);

  state_e             state_q, state_d;
  logic               dw_flag_q, dw_flag_d;
  logic               pass_cnt_q, pass_cnt_d;
  logic [TIMER_W-1:0] tc_c;
  logic               timed_c;
  logic               timer_clear_c;
  logic               timer_freeze_c;
  logic               phase_end;

  // Terminal count of the current phase, from registered state only.
  always_comb begin
    tc_c    = '0;
    timed_c = 1'b1;
    case (state_q)
      ST_FILL:  tc_c = TC_FILL;
      ST_WASH:  tc_c = TC_WASH;
      ST_RINSE: tc_c = TC_RINSE;
      ST_SPIN:  tc_c = TC_SPIN;
      default:  timed_c = 1'b0;
    endcase
  end

  assign timer_freeze_c = (state_q == ST_SPIN) && bus.timer_pause;

  always_comb begin
    state_d    = state_q;
    dw_flag_d  = dw_flag_q;
    pass_cnt_d = pass_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.coin_in) begin
          state_d    = ST_FILL;
          dw_flag_d  = bus.double_wash;
          pass_cnt_d = 1'b0;
        end
      end
      ST_FILL:  if (phase_end) state_d = ST_WASH;
      ST_WASH:  if (phase_end) state_d = ST_RINSE;
      ST_RINSE: begin
        if (phase_end) begin
          if (dw_flag_q && !pass_cnt_q) begin
            state_d    = ST_WASH;
            pass_cnt_d = 1'b1;
          end else begin
            state_d = ST_SPIN;
          end
        end
      end
      ST_SPIN:  if (phase_end) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Restart the timer on every state entry; park it at zero in untimed states.
  assign timer_clear_c = (state_d != state_q) || !timed_c;

  always_ff @(posedge clk or negedge Counter_RST) begin
    if (!Counter_RST) begin
      state_q    <= ST_IDLE;
      dw_flag_q  <= 1'b0;
      pass_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dw_flag_q  <= dw_flag_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end

  phase_timer u_timer (
    .clk       (clk),
    .rst_n     (Counter_RST),
    .clear     (timer_clear_c),
    .freeze    (timer_freeze_c),
    .tc        (tc_c),
    .phase_end (phase_end)
  );

  assign bus.state_o    = 3'(state_q);
  assign bus.fill_valve = (state_q == ST_FILL);
  assign bus.wash_motor = (state_q == ST_WASH) || (state_q == ST_RINSE);
  assign bus.spin_motor = (state_q == ST_SPIN) && !bus.timer_pause;
  assign bus.wash_done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_wash_cycle_sequencer.sv
// Directed bench for wash_cycle_sequencer with short phases
// (FILL 2, WASH 3, RINSE 2, SPIN 1 cycles).
module tb_wash_cycle_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  wash_cycle_sequencer_if bus();

  wash_cycle_sequencer #(
    .FILL_SEC    (2),
    .WASH_SEC    (3),
    .RINSE_SEC   (2),
    .SPIN_SEC    (1),
    .CYC_PER_SEC (1)
  ) u_dut (
    .clk         (clk),
    .Counter_RST (rst_n),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_RINSE = 3'd3;
  localparam logic [2:0] S_SPIN  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Expected {state_o, fill_valve, wash_motor, spin_motor, wash_done}.
  function automatic logic [6:0] exp_vec(input logic [2:0] st, input logic pz);
    return {st, (st == S_FILL), (st == S_WASH) || (st == S_RINSE),
            (st == S_SPIN) && !pz, (st == S_DONE)};
  endfunction

  task automatic check(input string tag, input logic [2:0] st);
    logic [6:0] obs;
    logic [6:0] expv;
    obs  = {bus.state_o, bus.fill_valve, bus.wash_motor, bus.spin_motor, bus.wash_done};
    expv = exp_vec(st, bus.timer_pause);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [2:0] st, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, st);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus.coin_in     = 1'b0;
    bus.double_wash = 1'b0;
    bus.timer_pause = 1'b0;
    #3;
    check("reset_state", S_IDLE);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run("idle_after_reset", S_IDLE, 2);

    // Single pass; double_wash raised after acceptance must be ignored.
    bus.coin_in = 1'b1;
    tick();
    check("s1_fill_entry", S_FILL);
    bus.coin_in     = 1'b0;
    bus.double_wash = 1'b1;
    run("s1_fill", S_FILL, 1);
    run("s1_wash", S_WASH, 3);
    bus.double_wash = 1'b0;
    run("s1_rinse", S_RINSE, 2);
    run("s1_spin", S_SPIN, 1);
    run("s1_done", S_DONE, 1);
    run("s1_idle", S_IDLE, 2);

    // Double wash: WASH and RINSE repeated once.
    bus.coin_in     = 1'b1;
    bus.double_wash = 1'b1;
    tick();
    check("s2_fill_entry", S_FILL);
    bus.coin_in     = 1'b0;
    bus.double_wash = 1'b0;
    run("s2_fill", S_FILL, 1);
    run("s2_wash1", S_WASH, 3);
    run("s2_rinse1", S_RINSE, 2);
    run("s2_wash2", S_WASH, 3);
    run("s2_rinse2", S_RINSE, 2);
    run("s2_spin", S_SPIN, 1);
    run("s2_done", S_DONE, 1);
    run("s2_idle", S_IDLE, 1);

    // Pause held 4 cycles across the terminal SPIN cycle.
    bus.coin_in = 1'b1;
    tick();
    check("s3_fill_entry", S_FILL);
    bus.coin_in = 1'b0;
    run("s3_fill", S_FILL, 1);
    run("s3_wash", S_WASH, 3);
    run("s3_rinse", S_RINSE, 2);
    run("s3_spin_run", S_SPIN, 1);
    bus.timer_pause = 1'b1;
    #1;
    check("s3_spin_pause_now", S_SPIN);
    run("s3_spin_paused", S_SPIN, 3);
    tick();
    check("s3_spin_paused_last", S_SPIN);
    bus.timer_pause = 1'b0;
    #1;
    check("s3_spin_release", S_SPIN);
    run("s3_done", S_DONE, 1);
    run("s3_idle", S_IDLE, 1);

    // Asynchronous reset during WASH aborts without a done pulse.
    bus.coin_in = 1'b1;
    tick();
    check("s4_fill_entry", S_FILL);
    bus.coin_in = 1'b0;
    run("s4_fill", S_FILL, 1);
    run("s4_wash", S_WASH, 1);
    #2 rst_n = 1'b0;
    #1;
    check("s4_async_reset", S_IDLE);
    run("s4_reset_hold", S_IDLE, 2);
    #2 rst_n = 1'b1;
    run("s4_after_reset", S_IDLE, 3);

    // Pause in WASH and coin toggled in RINSE leave timing unchanged.
    bus.coin_in = 1'b1;
    tick();
    check("s5_fill_entry", S_FILL);
    bus.coin_in = 1'b0;
    run("s5_fill", S_FILL, 1);
    bus.timer_pause = 1'b1;
    run("s5_wash_paused", S_WASH, 3);
    bus.timer_pause = 1'b0;
    bus.coin_in     = 1'b1;
    run("s5_rinse_coin", S_RINSE, 1);
    bus.coin_in     = 1'b0;
    run("s5_rinse", S_RINSE, 1);
    run("s5_spin", S_SPIN, 1);
    run("s5_done", S_DONE, 1);
    run("s5_idle", S_IDLE, 1);

    // Coin held through DONE restarts after one IDLE cycle.
    bus.coin_in = 1'b1;
    tick();
    check("s6_fill_entry", S_FILL);
    run("s6_fill", S_FILL, 1);
    run("s6_wash", S_WASH, 3);
    run("s6_rinse", S_RINSE, 2);
    run("s6_spin", S_SPIN, 1);
    run("s6_done", S_DONE, 1);
    run("s6_idle", S_IDLE, 1);
    run("s6_restart", S_FILL, 1);
    bus.coin_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("s6_reset", S_IDLE);
    #2 rst_n = 1'b1;
    run("s6_idle_end", S_IDLE, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wash_cycle_sequencer.md
WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 Parameter FILL_SEC, default 120, fill phase duration in seconds.
REQ-002 Parameter WASH_SEC, default 300, wash phase duration in seconds.
REQ-003 Parameter RINSE_SEC, default 120, rinse phase duration in seconds.
REQ-004 Parameter SPIN_SEC, default 60, spin phase duration in seconds.
REQ-005 Parameter CYC_PER_SEC, default 1, clk cycles per second.
REQ-006 Port clk  input  1  clock, all state changes on rising edge.
REQ-007 Port Counter_RST  input  1  reset, asynchronous, active-low.
REQ-008 Port coin_in  input  1  start request, level; honoured only in IDLE.
REQ-009 Port double_wash  input  1  second wash+rinse pass requested; sampled on coin acceptance.
REQ-010 Port timer_pause  input  1  freeze request; honoured only in SPIN.
REQ-011 Port state_o  output  3  current state code.
REQ-012 Port fill_valve  output  1  high in FILL only.
REQ-013 Port wash_motor  output  1  high in WASH and RINSE.
REQ-014 Port spin_motor  output  1  high in SPIN while not paused.
REQ-015 Port wash_done  output  1  one-cycle pulse on DONE.

Function
REQ-016 States, codes: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5; codes 6-7 SHALL return to IDLE next cycle.
REQ-017 IDLE -> FILL on cycle after coin_in=1; double_wash latched into dw_flag, pass_cnt cleared, same edge.
REQ-018 Each timed phase SHALL last exactly <PHASE>_SEC*CYC_PER_SEC unpaused cycles; phase timer 32-bit, cleared on every state entry.
REQ-019 phase_end SHALL assert combinationally when timer == N-1 and not frozen; state advances on that edge.
REQ-020 Sequence FILL -> WASH -> RINSE; after RINSE: if dw_flag=1 and pass_cnt=0 -> WASH with pass_cnt=1, else -> SPIN.
REQ-021 SPIN -> DONE at phase_end; DONE -> IDLE unconditionally after exactly one cycle.
REQ-022 In SPIN, timer_pause=1 SHALL freeze timer and drop spin_motor same cycle (combinational from input); state held; release resumes from frozen count.
REQ-023 timer_pause outside SPIN SHALL have no effect; coin_in and double_wash outside IDLE ignored.
REQ-024 timer_pause=1 at the terminal count cycle of SPIN SHALL block the transition until released.
REQ-025 Outputs fill_valve, wash_motor, wash_done SHALL be decoded from registered state only (glitch-free).
REQ-026 Any phase duration of 0 SHALL be treated as 1 cycle.
REQ-027 coin_in held high through DONE SHALL start a new cycle on the IDLE cycle after DONE.

Reset
REQ-028 Counter_RST=0 SHALL asynchronously force state IDLE, timer 0, dw_flag 0, pass_cnt 0, all outputs 0, state_o 0.
REQ-029 Reset asserted mid-phase SHALL abort the cycle; no wash_done pulse; deassertion synchronised externally.

Structure
REQ-030 Shared package wash_pkg SHALL hold the state-code enum and phase-duration defaults.
REQ-031 Timer SHALL be sub-module phase_timer (inputs clear, freeze, terminal count; output phase_end); FSM in parent.

Verification (FILL_SEC=2, WASH_SEC=3, RINSE_SEC=2, SPIN_SEC=1, CYC_PER_SEC=1)
REQ-032 coin_in pulse, double_wash=0 -> FILL 2, WASH 3, RINSE 2, SPIN 1, DONE 1 cycles; wash_done one pulse.
REQ-033 coin_in with double_wash=1 -> WASH,RINSE repeated once; DONE 5 cycles later than REQ-032.
REQ-034 timer_pause=1 for 4 cycles during SPIN -> spin_motor 0 those cycles, SPIN extended by exactly 4 cycles.
REQ-035 Counter_RST=0 during WASH -> state_o=0 and all outputs 0 immediately, no wash_done.
REQ-036 timer_pause=1 in WASH and coin_in toggled in RINSE -> timing identical to REQ-032.
